// File: rtl/bch_pkg.sv
// ---------------------------------------------------------------------------
// bch_pkg
// Shared constants, status encodings, FSM state type and the GF(2^6)
// alpha-multiply helper for the BCH(63,56) SEC-DED decoder.
// ---------------------------------------------------------------------------
package bch_pkg;

  localparam int N = 63;   // codeword length
  localparam int K = 56;   // message length, message sits in R[62:7]
  localparam int M = 6;    // field degree

  // Low-order terms of the primitive polynomial x^6 + x + 1.
  localparam logic [5:0] PRIM_LOW = 6'b000011;

  localparam logic [1:0] ST_CLEAN  = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_DOUBLE = 2'd2;
  localparam logic [1:0] ST_ODD0   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYND   = 3'd1,
    S_EVAL   = 3'd2,
    S_SEARCH = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Multiply a GF(2^6) element by alpha: shift left and fold x^6 back in
  // as x + 1 whenever the top bit falls off.
  function automatic logic [5:0] mul_alpha(input logic [5:0] a);
    logic [5:0] y;
    y = {a[4:0], 1'b0};
    if (a[5]) begin
      y = y ^ PRIM_LOW;
    end else begin
      y = y;
    end
    return y;
  endfunction

endpackage

// File: rtl/bch_sec_ded_decoder_gf64_mul_alpha.sv
// ---------------------------------------------------------------------------
// gf64_mul_alpha
// Purely combinational multiply-by-alpha in GF(2^6), poly x^6 + x + 1.
// Ports:
//   val  in  6  field element
//   prod out 6  alpha * val
// ---------------------------------------------------------------------------
module gf64_mul_alpha
  import bch_pkg::*;
(
  input  logic [5:0] val,
  output logic [5:0] prod
);

  assign prod = mul_alpha(val);

endmodule

// File: rtl/bch_sec_ded_decoder.sv
// ---------------------------------------------------------------------------
// bch_sec_ded_decoder
// Bit-serial SEC-DED decoder for BCH(63,56). A rising edge on Mistake_Done
// captures R, accumulates S1 = r(alpha) and overall parity over 63 cycles,
// classifies the error, and for a single error searches alpha^k == S1 to
// locate and flip the bad bit.
// Ports:
//   clk           in   1   rising-edge clock
//   rst_n         in   1   asynchronous active-low reset
//   R             in   63  received word, R[i] is coefficient of x^i
//   Mistake_Done  in   1   upstream level; 0->1 starts a decode
//   Cor           out  63  corrected codeword
//   Data          out  56  Cor[62:7]
//   err_stat      out  2   0 clean, 1 single fixed, 2 double, 3 S1=0 & P=1
//   err_loc       out  6   corrected bit index when err_stat == 1, else 0
//   Decode_Done   out  1   high from completion to next start or reset
// ---------------------------------------------------------------------------
module bch_sec_ded_decoder
  import bch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] R,
  input  logic         Mistake_Done,
  output logic [N-1:0] Cor,
  output logic [K-1:0] Data,
  output logic [1:0]   err_stat,
  output logic [M-1:0] err_loc,
  output logic         Decode_Done
);

  state_e         state_r, state_nx_s;
  logic           md_q_r;
  logic           start_s;
  logic [N-1:0]   r_sh_r, r_sh_nx_s;
  logic [N-1:0]   cor_r, cor_nx_s;
  logic [M-1:0]   s_r, s_nx_s;
  logic           p_r, p_nx_s;
  logic [5:0]     cnt_r, cnt_nx_s;
  logic [M-1:0]   t_r, t_nx_s;
  logic [5:0]     k_r, k_nx_s;
  logic [1:0]     stat_r, stat_nx_s;
  logic [M-1:0]   loc_r, loc_nx_s;
  logic           done_r, done_nx_s;
  logic [M-1:0]   s_alpha_s;
  logic [M-1:0]   t_alpha_s;
  logic [N-1:0]   flip_mask_s;

  assign start_s     = Mistake_Done & ~md_q_r;
  assign flip_mask_s = {{(N-1){1'b0}}, 1'b1} << k_r;

  // Horner step for the syndrome accumulator.
  gf64_mul_alpha u_mul_s (
    .val  (s_r),
    .prod (s_alpha_s)
  );

  // Walks alpha^k during the error-location search.
  gf64_mul_alpha u_mul_t (
    .val  (t_r),
    .prod (t_alpha_s)
  );

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_nx_s = state_r;
    r_sh_nx_s  = r_sh_r;
    cor_nx_s   = cor_r;
    s_nx_s     = s_r;
    p_nx_s     = p_r;
    cnt_nx_s   = cnt_r;
    t_nx_s     = t_r;
    k_nx_s     = k_r;
    stat_nx_s  = stat_r;
    loc_nx_s   = loc_r;
    done_nx_s  = done_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_s) begin
          r_sh_nx_s  = R;
          cor_nx_s   = R;
          s_nx_s     = 6'd0;
          p_nx_s     = 1'b0;
          cnt_nx_s   = 6'd62;
          stat_nx_s  = ST_CLEAN;
          loc_nx_s   = 6'd0;
          done_nx_s  = 1'b0;
          state_nx_s = S_SYND;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_SYND: begin
        // MSB first, so after 63 steps s_r holds r(alpha).
        s_nx_s    = s_alpha_s ^ {5'd0, r_sh_r[N-1]};
        p_nx_s    = p_r ^ r_sh_r[N-1];
        r_sh_nx_s = {r_sh_r[N-2:0], 1'b0};
        cnt_nx_s  = cnt_r - 6'd1;
        if (cnt_r == 6'd0) begin
          state_nx_s = S_EVAL;
        end else begin
          state_nx_s = S_SYND;
        end
      end
      S_EVAL: begin
        if ((s_r != 6'd0) && p_r) begin
          t_nx_s     = 6'b000001;
          k_nx_s     = 6'd0;
          state_nx_s = S_SEARCH;
        end else if (s_r != 6'd0) begin
          stat_nx_s  = ST_DOUBLE;
          done_nx_s  = 1'b1;
          state_nx_s = S_DONE;
        end else if (p_r) begin
          stat_nx_s  = ST_ODD0;
          done_nx_s  = 1'b1;
          state_nx_s = S_DONE;
        end else begin
          stat_nx_s  = ST_CLEAN;
          done_nx_s  = 1'b1;
          state_nx_s = S_DONE;
        end
      end
      S_SEARCH: begin
        // A nonzero syndrome is always some alpha^k with k <= 62, so this
        // loop terminates without a guard counter.
        if (t_r == s_r) begin
          cor_nx_s   = cor_r ^ flip_mask_s;
          loc_nx_s   = k_r;
          stat_nx_s  = ST_SINGLE;
          done_nx_s  = 1'b1;
          state_nx_s = S_DONE;
        end else begin
          t_nx_s     = t_alpha_s;
          k_nx_s     = k_r + 6'd1;
          state_nx_s = S_SEARCH;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath, edge-detect and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_q_r <= 1'b0;
      r_sh_r <= '0;
      cor_r  <= '0;
      s_r    <= 6'd0;
      p_r    <= 1'b0;
      cnt_r  <= 6'd0;
      t_r    <= 6'd0;
      k_r    <= 6'd0;
      stat_r <= 2'd0;
      loc_r  <= 6'd0;
      done_r <= 1'b0;
    end else begin
      md_q_r <= Mistake_Done;
      r_sh_r <= r_sh_nx_s;
      cor_r  <= cor_nx_s;
      s_r    <= s_nx_s;
      p_r    <= p_nx_s;
      cnt_r  <= cnt_nx_s;
      t_r    <= t_nx_s;
      k_r    <= k_nx_s;
      stat_r <= stat_nx_s;
      loc_r  <= loc_nx_s;
      done_r <= done_nx_s;
    end
  end

  assign Cor         = cor_r;
  assign Data        = cor_r[N-1:N-K];
  assign err_stat    = stat_r;
  assign err_loc     = loc_r;
  assign Decode_Done = done_r;

endmodule

// File: tb/tb_bch_sec_ded_decoder.sv
module tb_bch_sec_ded_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [62:0] R = '0;
  logic        Mistake_Done = 1'b0;
  logic [62:0] Cor;
  logic [55:0] Data;
  logic [1:0]  err_stat;
  logic [5:0]  err_loc;
  logic        Decode_Done;

  bch_sec_ded_decoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .R            (R),
    .Mistake_Done (Mistake_Done),
    .Cor          (Cor),
    .Data         (Data),
    .err_stat     (err_stat),
    .err_loc      (err_loc),
    .Decode_Done  (Decode_Done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [62:0] cor;
    logic [1:0]  stat;
    logic [5:0]  loc;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   apow [0:62];
  int   total = 0;
  int   bad = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input logic [62:0] act, input logic [62:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: S1 as the sum of alpha^i over set bits, P as population parity,
  // error location as the discrete log of S1.
  function automatic exp_t model(input logic [62:0] r);
    exp_t e;
    int s = 0;
    int p = 0;
    for (int i = 0; i < 63; i++) if (r[i]) begin s = s ^ apow[i]; p = p ^ 1; end
    e.cor = r; e.loc = 6'd0; e.start_cyc = 0;
    if (s == 0 && p == 0)      begin e.stat = 2'd0; e.lat = 65; end
    else if (p == 0)           begin e.stat = 2'd2; e.lat = 65; end
    else if (s == 0)           begin e.stat = 2'd3; e.lat = 65; end
    else begin
      e.stat = 2'd1; e.lat = 0;
      for (int k = 0; k < 63; k++)
        if (apow[k] == s) begin e.loc = 6'(k); e.cor = r ^ (63'd1 << k); e.lat = 66 + k; end
    end
    return e;
  endfunction

  // Monitor: compare each completed decode against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && Decode_Done && !done_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 63'd1, 63'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("cor", Cor, e.cor);
        chk("data", {7'd0, Data}, {7'd0, e.cor[62:7]});
        chk("stat", {61'd0, err_stat}, {61'd0, e.stat});
        chk("loc", {57'd0, err_loc}, {57'd0, e.loc});
        chk("latency", 63'(cyc - e.start_cyc + 1), 63'(e.lat));
      end
    end
    done_prev = Decode_Done;
  end

  task automatic issue(input logic [62:0] r);
    exp_t e;
    @(negedge clk);
    R = r;
    Mistake_Done = 1'b1;
    e = model(r);
    e.start_cyc = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Decode_Done && n < 200) begin @(negedge clk); n++; end
    if (!Decode_Done) chk("done_timeout", 63'd0, 63'd1);
  endtask

  task automatic decode(input logic [62:0] r);
    issue(r);
    @(negedge clk);
    wait_done();
    @(negedge clk);
    Mistake_Done = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cor"}, Cor, 63'd0);
    chk({tag, "_data"}, {7'd0, Data}, 63'd0);
    chk({tag, "_stat"}, {61'd0, err_stat}, 63'd0);
    chk({tag, "_loc"}, {57'd0, err_loc}, 63'd0);
    chk({tag, "_done"}, {62'd0, Decode_Done}, 63'd0);
  endtask

  initial begin
    int a = 1;
    logic [62:0] g;
    logic [62:0] cw;
    for (int i = 0; i < 63; i++) begin
      apow[i] = a;
      a = a * 2;
      if (a >= 64) a = a ^ 67;
    end
    g = 63'h0C5;  // (x+1)(x^6+x+1)

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    decode(63'd0);
    decode(63'd1 << 5);
    decode(63'd1 << 62);
    decode(63'h3);
    decode(63'h43);

    for (int t = 0; t < 40; t++) begin
      int nerr;
      cw = '0;
      for (int j = 0; j < 56; j++) if ($urandom_range(0, 1) == 1) cw = cw ^ (g << j);
      nerr = $urandom_range(0, 3);
      for (int e = 0; e < nerr; e++) cw = cw ^ (63'd1 << $urandom_range(0, 62));
      decode(cw);
    end

    // Abort mid-syndrome with reset, then restart and poke start during SEARCH.
    issue(63'h7FFF_0000_1234_5678);
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    Mistake_Done = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(63'd1 << 5);
    repeat (66) @(posedge clk);
    @(negedge clk);
    Mistake_Done = 1'b0;
    @(negedge clk);
    Mistake_Done = 1'b1;
    @(negedge clk);
    wait_done();
    repeat (5) @(negedge clk);
    chk("hold_done", {62'd0, Decode_Done}, 63'd1);
    chk("hold_stat", {61'd0, err_stat}, 63'd1);
    chk("hold_loc", {57'd0, err_loc}, 63'd5);
    chk("queue_empty", 63'(sb_q.size()), 63'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bch_sec_ded_decoder.md
# bch_sec_ded_decoder

Serial SEC-DED decoder for the BCH(63,56) datapath; sits directly downstream of the error-injection stage, consuming its corrupted word `R` and its `Mistake_Done` flag. It computes the GF(2^6) syndrome `S1 = r(α)` and the overall parity `P` bit-serially. It classifies the error pattern as none, single, double or odd-undetectable. For a single error it locates the bit by sequential power search and corrects it. It outputs the corrected codeword, the 56-bit message, status and a done flag.

## Interface
- `N`, 63: codeword length.
- `K`, 56: message length; message occupies `R[62:7]`.
- `M`, 6: field degree; primitive polynomial x^6+x+1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `R`  in  63  received word; `R[i]` is the coefficient of x^i.
- `Mistake_Done`  in  1  level from the upstream stage; a 0→1 transition starts a decode.
- `Cor`  out  63  corrected codeword.
- `Data`  out  56  `Cor[62:7]`.
- `err_stat`  out  2  0 = clean, 1 = single corrected, 2 = double detected, 3 = S1=0 with P=1 (uncorrectable).
- `err_loc`  out  6  corrected bit index; valid only when `err_stat`=1, else 0.
- `Decode_Done`  out  1  high from completion until the next start or reset.

## Operation
- States: IDLE, SYND, EVAL, SEARCH, DONE.
- `md_q` registers `Mistake_Done`; `start = Mistake_Done & ~md_q`.
- IDLE/DONE with `start`:
  - `r_sh ← R`, `Cor ← R`, `S ← 0`, `P ← 0`, `cnt ← 62`.
  - `Decode_Done ← 0`, `err_stat ← 0`, `err_loc ← 0`; go to SYND.
- SYND, 63 edges, bit-serial from MSB:
  - `b = r_sh[62]`, `S ← α·S ⊕ b`, `P ← P ⊕ b`, `r_sh ← r_sh<<1`.
  - `cnt` decrements; after the edge with `cnt`=0, go to EVAL.
- α·S: `{S[4:0],0}`; if `S[5]`=1, XOR with 6'b000011.
- EVAL, 1 edge:
  - S=0, P=0 → stat 0, DONE.
  - S≠0, P=0 → stat 2, DONE.
  - S=0, P=1 → stat 3, DONE.
  - S≠0, P=1 → `T ← 6'b000001`, `k ← 0`, SEARCH.
- SEARCH, each edge:
  - If `T==S`: `Cor[k] ← ~Cor[k]`, `err_loc ← k`, stat 1, DONE.
  - Otherwise `T ← α·T`, `k ← k+1`.
- A nonzero S always matches at some k ≤ 62, so no timeout is required.
- DONE: `Decode_Done`=1; outputs hold.
- Mid-decode behaviour:
  - `start` is ignored outside IDLE/DONE.
  - `R` changes after capture are ignored.
- Triple errors with P=1 and S≠0 are miscorrected as single errors. This is inherent to SEC-DED and is not flagged.

## Timing
- Reset values: all outputs 0; state IDLE; `md_q` 0. Reset is asynchronous and aborts any decode immediately.
- Edge 1 is the edge sampling `start`. `Decode_Done` rises after:
  - edge 65 when stat ∈ {0,2,3};
  - edge 66+k for a single error at bit k, so 66–128 edges.
- `Cor`, `Data`, `err_stat` and `err_loc` are final on the same edge that `Decode_Done` rises.
- Upstream holds `Mistake_Done` high after completion, so one decode runs per rising edge. Re-arming needs reset or `Mistake_Done` returning low.

## Structure
- Package `bch_pkg`:
  - N, K, M;
  - `PRIM_LOW = 6'b000011`;
  - status encodings `ST_CLEAN`, `ST_SINGLE`, `ST_DOUBLE`, `ST_ODD0`;
  - state enum.
- Sub-module `gf64_mul_alpha`, purely combinational 6-bit α-multiply. It is instantiated twice, once for S in SYND and once for T in SEARCH.
- FSM, counters and registers live in the top module.

## Test plan
- R = 0, `Mistake_Done` 0→1 → stat 0, `Cor`=0, `Data`=0, `Decode_Done` after edge 65.
- R = 1<<5 → S=6'b100000, P=1, stat 1, `err_loc`=5, `Cor`=0, done after edge 71.
- R = 1<<62 → S=6'b100001, stat 1, `err_loc`=62, `Cor`=0, done after edge 128.
- R = bits {0,1} set → S=6'b000011, P=0, stat 2, `Cor`=R, done after edge 65.
- R = bits {0,1,6} set → S=0, P=1, stat 3, `Cor`=R.
- Reset asserted at edge 30 of SYND, then released and restarted with R = 1<<5:
  - all outputs 0 during reset;
  - the restarted decode completes identically to scenario 2;
  - a second `start` pulse in SEARCH is ignored.
